lookupflow_tcam: RTL and testbench

Parametrised flow-table lookup engine; successor to the fixed-table `lookupflow`. It holds DEPTH software-programmed entries, each with a key, a per-bit care mask, a forward-port bitmap and a saturating hit counter. A request is matched by sequential priority scan, lowest index wins. It sits between the header parser (`of_lookup_*` handshake, unchanged semantics) and the output-port scheduler, with a config port toward the CPU-side register bank.

---
 rtl/lookupflow_tcam.sv | 155 +++++++++++++++
 tb/tb_lookupflow_tcam.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookupflow_tcam.sv
// Flow-table lookup engine: DEPTH ternary entries scanned one per cycle, lowest index wins.
// Each entry carries a forward-port bitmap and a saturating hit counter readable from the CPU port.
module lookupflow_tcam #(
    parameter int NPORT = 4,
    parameter int DEPTH = 8,
    parameter int KEY_W = 243,
    parameter int CNT_W = 32,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             of_lookup_req,
    input  logic [KEY_W-1:0] of_lookup_data,
    output logic             of_lookup_ack,
    output logic             of_lookup_err,
    output logic [NPORT-1:0] of_lookup_fwd_port,
    output logic [IW-1:0]    of_lookup_hit_idx,
    output logic             of_lookup_busy,
    input  logic             cfg_wr_en,
    input  logic [IW-1:0]    cfg_wr_idx,
    input  logic             cfg_wr_valid,
    input  logic [KEY_W-1:0] cfg_wr_key,
    input  logic [KEY_W-1:0] cfg_wr_mask,
    input  logic [NPORT-1:0] cfg_wr_port,
    input  logic [IW-1:0]    cfg_rd_idx,
    output logic [CNT_W-1:0] cfg_rd_cnt
);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [KEY_W-1:0]   req_key_q, req_key_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [NPORT-1:0]   fwd_q, fwd_d;
    logic [IW-1:0]      hit_idx_q, hit_idx_d;
    logic [CNT_W-1:0]   rd_cnt_q;

    logic               ent_valid_q [DEPTH];
    logic [KEY_W-1:0]   ent_key_q   [DEPTH];
    logic [KEY_W-1:0]   ent_mask_q  [DEPTH];
    logic [NPORT-1:0]   ent_port_q  [DEPTH];
    logic [CNT_W-1:0]   ent_cnt_q   [DEPTH];

    logic               match;
    logic               last_idx;
    logic               hit_inc;

    // Only the entry under the scan pointer is compared, reading pre-write table contents.
    assign match    = ent_valid_q[idx_q]
                   && (((req_key_q ^ ent_key_q[idx_q]) & ent_mask_q[idx_q]) == '0);
    assign last_idx = (idx_q == IW'(DEPTH - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        req_key_d = req_key_q;
        ack_d     = 1'b0;
        err_d     = err_q;
        fwd_d     = fwd_q;
        hit_idx_d = hit_idx_q;
        hit_inc   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (of_lookup_req) begin
                    req_key_d = of_lookup_data;
                    idx_d     = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (match) begin
                    ack_d     = 1'b1;
                    err_d     = 1'b0;
                    fwd_d     = ent_port_q[idx_q];
                    hit_idx_d = idx_q;
                    hit_inc   = 1'b1;
                    state_d   = S_IDLE;
                end else if (last_idx) begin
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    fwd_d     = '0;
                    hit_idx_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            req_key_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            fwd_q     <= '0;
            hit_idx_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            req_key_q <= req_key_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            fwd_q     <= fwd_d;
            hit_idx_q <= hit_idx_d;
            rd_cnt_q  <= ent_cnt_q[cfg_rd_idx];
        end
    end

    // NOTE: the table is held in flops with a full reset because sys_rst must leave every entry invalid and every counter at zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_q[i] <= 1'b0;
                ent_key_q[i]   <= '0;
                ent_mask_q[i]  <= '0;
                ent_port_q[i]  <= '0;
                ent_cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // A config write to the entry being hit wins: the counter restarts at zero.
                if (cfg_wr_en && (cfg_wr_idx == IW'(i))) begin
                    ent_valid_q[i] <= cfg_wr_valid;
                    ent_key_q[i]   <= cfg_wr_key;
                    ent_mask_q[i]  <= cfg_wr_mask;
                    ent_port_q[i]  <= cfg_wr_port;
                    ent_cnt_q[i]   <= '0;
                end else if (hit_inc && (idx_q == IW'(i)) && !(&ent_cnt_q[i])) begin
                    ent_cnt_q[i] <= ent_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign of_lookup_ack      = ack_q;
    assign of_lookup_err      = err_q;
    assign of_lookup_fwd_port = fwd_q;
    assign of_lookup_hit_idx  = hit_idx_q;
    assign of_lookup_busy     = (state_q == S_SCAN);
    assign cfg_rd_cnt         = rd_cnt_q;

endmodule

// File: tb/tb_lookupflow_tcam.sv
// Self-checking bench for lookupflow_tcam: vector table plus hand sequences for handshake,
// counter saturation/write collision and mid-scan reset; acks are scored against a queue.
module tb_lookupflow_tcam;

    localparam int NPORT = 4;
    localparam int DEPTH = 8;
    localparam int KEY_W = 243;
    localparam int CNT_W = 4;
    localparam int IW    = 3;

    localparam logic [31:0] IP_NET = 32'h0A00_0000;
    localparam logic [31:0] IP1    = 32'h0A00_0001;
    localparam logic [31:0] IP2    = 32'h0A00_0002;
    localparam logic [31:0] IP3    = 32'h0A00_0003;
    localparam logic [31:0] IP5    = 32'h0A00_0005;
    localparam logic [31:0] IP7    = 32'h0A00_0007;
    localparam logic [31:0] IP9    = 32'h0A00_0009;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             req = 1'b0;
    logic [KEY_W-1:0] data = '0;
    logic             ack, err, busy;
    logic [NPORT-1:0] fwd;
    logic [IW-1:0]    hit_idx;
    logic             wr_en = 1'b0;
    logic [IW-1:0]    wr_idx = '0;
    logic             wr_valid = 1'b0;
    logic [KEY_W-1:0] wr_key = '0;
    logic [KEY_W-1:0] wr_mask = '0;
    logic [NPORT-1:0] wr_port = '0;
    logic [IW-1:0]    rd_idx = '0;
    logic [CNT_W-1:0] rd_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic             err;
        logic [NPORT-1:0] port;
        logic [IW-1:0]    idx;
        int               sample_cyc;
        int               lat;
    } exp_t;

    typedef struct {
        bit               do_wr;
        logic [IW-1:0]    wr_idx;
        logic             wr_valid;
        logic [31:0]      wr_ip;
        logic [31:0]      wr_mip;
        logic [NPORT-1:0] wr_port;
        logic [31:0]      look_ip;
        logic             exp_err;
        logic [NPORT-1:0] exp_port;
        logic [IW-1:0]    exp_idx;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   model_cnt [DEPTH];
    vec_t vecs [8];

    lookupflow_tcam #(
        .NPORT(NPORT), .DEPTH(DEPTH), .KEY_W(KEY_W), .CNT_W(CNT_W)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .of_lookup_req      (req),
        .of_lookup_data     (data),
        .of_lookup_ack      (ack),
        .of_lookup_err      (err),
        .of_lookup_fwd_port (fwd),
        .of_lookup_hit_idx  (hit_idx),
        .of_lookup_busy     (busy),
        .cfg_wr_en          (wr_en),
        .cfg_wr_idx         (wr_idx),
        .cfg_wr_valid       (wr_valid),
        .cfg_wr_key         (wr_key),
        .cfg_wr_mask        (wr_mask),
        .cfg_wr_port        (wr_port),
        .cfg_rd_idx         (rd_idx),
        .cfg_rd_cnt         (rd_cnt)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [KEY_W-1:0] mk_key(input logic [31:0] ip, input bit noise);
        logic [KEY_W-1:0] k = '0;
        if (noise)
            for (int b = 0; b < KEY_W; b++) k[b] = 1'($urandom_range(0, 1));
        k[79:48] = ip;
        return k;
    endfunction

    function automatic logic [KEY_W-1:0] mk_mask(input logic [31:0] m);
        logic [KEY_W-1:0] k = '0;
        k[79:48] = m;
        return k;
    endfunction

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (ack) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 64'(1), 64'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_err", 64'(err), 64'(mon_e.err));
                check("ack_fwd", 64'(fwd), 64'(mon_e.port));
                check("ack_hit_idx", 64'(hit_idx), 64'(mon_e.idx));
                check("ack_latency", 64'(cyc - mon_e.sample_cyc), 64'(mon_e.lat));
            end
        end
    end

    function automatic exp_t mk_exp(input logic e, input logic [NPORT-1:0] p,
                                     input logic [IW-1:0] i, input int sample);
        exp_t x;
        x.err        = e;
        x.port       = e ? '0 : p;
        x.idx        = e ? '0 : i;
        x.sample_cyc = sample;
        x.lat        = e ? DEPTH : int'(i) + 1;
        return x;
    endfunction

    function automatic void model_hit(input logic e, input logic [IW-1:0] i);
        if (!e && model_cnt[i] < (1 << CNT_W) - 1) model_cnt[i]++;
    endfunction

    task automatic wait_idle();
        for (int k = 0; k < 64 && sb_q.size() != 0; k++) @(negedge sys_clk);
        if (sb_q.size() != 0) begin
            check("ack_timeout", 64'(sb_q.size()), 64'(0));
            sb_q.delete();
        end
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic v, input logic [31:0] ip,
                             input logic [31:0] mip, input logic [NPORT-1:0] port);
        wr_en    = 1'b1;
        wr_idx   = idx;
        wr_valid = v;
        wr_key   = mk_key(ip, 1'b0);
        wr_mask  = mk_mask(mip);
        wr_port  = port;
        model_cnt[idx] = 0;
        @(negedge sys_clk);
        wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] ip, input bit noise, input logic e,
                          input logic [NPORT-1:0] p, input logic [IW-1:0] i);
        data = mk_key(ip, noise);
        req  = 1'b1;
        sb_q.push_back(mk_exp(e, p, i, cyc + 1));
        model_hit(e, i);
        @(negedge sys_clk);
        req = 1'b0;
        wait_idle();
    endtask

    task automatic read_cnt(input string name, input logic [IW-1:0] idx, input int exp);
        rd_idx = idx;
        @(negedge sys_clk);
        check(name, 64'(rd_cnt), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        vecs[0] = '{1'b1, 3'd3, 1'b1, IP2,    32'hFFFF_FFFF, 4'b0010, IP2,          1'b0, 4'b0010, 3'd3};
        vecs[1] = '{1'b0, 3'd0, 1'b0, 32'd0,  32'd0,         4'b0000, IP3,          1'b1, 4'b0000, 3'd0};
        vecs[2] = '{1'b1, 3'd1, 1'b1, IP_NET, 32'hFFFF_FF00, 4'b0100, IP2,          1'b0, 4'b0100, 3'd1};
        vecs[3] = '{1'b1, 3'd1, 1'b0, 32'd0,  32'd0,         4'b0000, IP2,          1'b0, 4'b0010, 3'd3};
        vecs[4] = '{1'b1, 3'd0, 1'b1, 32'd0,  32'd0,         4'b1001, 32'hC0A80101, 1'b0, 4'b1001, 3'd0};
        vecs[5] = '{1'b1, 3'd0, 1'b0, 32'd0,  32'd0,         4'b0000, IP5,          1'b1, 4'b0000, 3'd0};
        vecs[6] = '{1'b0, 3'd0, 1'b0, 32'd0,  32'd0,         4'b0000, IP2,          1'b0, 4'b0010, 3'd3};
        vecs[7] = '{1'b1, 3'd7, 1'b1, IP9,    32'hFFFF_FFFF, 4'b1000, IP9,          1'b0, 4'b1000, 3'd7};
        for (int i = 0; i < DEPTH; i++) model_cnt[i] = 0;

        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("reset_outputs", 64'({ack, err, fwd, hit_idx, busy, rd_cnt}), 64'(0));

        // Empty table: miss after DEPTH cycles, busy high for exactly those cycles.
        data = mk_key(IP1, 1'b0);
        req  = 1'b1;
        sb_q.push_back(mk_exp(1'b1, '0, '0, cyc + 1));
        busy_cnt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge sys_clk);
            req = 1'b0;
            busy_cnt += int'(busy);
        end
        @(negedge sys_clk);
        check("empty_busy_cycles", 64'(busy_cnt), 64'(DEPTH));
        check("empty_busy_low_at_ack", 64'(busy), 64'(0));
        wait_idle();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_wr)
                cfg_write(vecs[v].wr_idx, vecs[v].wr_valid, vecs[v].wr_ip, vecs[v].wr_mip, vecs[v].wr_port);
            lookup(vecs[v].look_ip, 1'b1, vecs[v].exp_err, vecs[v].exp_port, vecs[v].exp_idx);
            if (!vecs[v].exp_err)
                read_cnt("vec_hit_cnt", vecs[v].exp_idx, model_cnt[vecs[v].exp_idx]);
        end

        // req pulsed mid-scan is dropped: the first lookup misses on schedule and only one ack appears.
        data = mk_key(IP3, 1'b0);
        req  = 1'b1;
        sb_q.push_back(mk_exp(1'b1, '0, '0, cyc + 1));
        @(negedge sys_clk);
        req = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        data = mk_key(IP2, 1'b0);
        req  = 1'b1;
        @(negedge sys_clk);
        req = 1'b0;
        wait_idle();
        repeat (12) @(negedge sys_clk);

        // req held through the ack cycle starts the next lookup with no gap.
        data = mk_key(IP2, 1'b0);
        req  = 1'b1;
        sb_q.push_back(mk_exp(1'b0, 4'b0010, 3'd3, cyc + 1));
        sb_q.push_back(mk_exp(1'b0, 4'b0010, 3'd3, cyc + 6));
        model_hit(1'b0, 3'd3);
        model_hit(1'b0, 3'd3);
        repeat (6) @(negedge sys_clk);
        req = 1'b0;
        wait_idle();
        repeat (12) @(negedge sys_clk);
        read_cnt("held_req_cnt", 3'd3, model_cnt[3]);

        // Counter saturation with CNT_W=4.
        cfg_write(3'd0, 1'b1, IP7, 32'hFFFF_FFFF, 4'b0001);
        for (int k = 0; k < 20; k++) lookup(IP7, 1'b1, 1'b0, 4'b0001, 3'd0);
        read_cnt("sat_cnt", 3'd0, 15);

        // Rewrite of entry 0 on the same edge as its hit: hit still reported, counter ends at 0.
        data = mk_key(IP7, 1'b0);
        req  = 1'b1;
        sb_q.push_back(mk_exp(1'b0, 4'b0001, 3'd0, cyc + 1));
        @(negedge sys_clk);
        req      = 1'b0;
        wr_en    = 1'b1;
        wr_idx   = 3'd0;
        wr_valid = 1'b1;
        wr_key   = mk_key(IP7, 1'b0);
        wr_mask  = mk_mask(32'hFFFF_FFFF);
        wr_port  = 4'b0001;
        @(negedge sys_clk);
        wr_en = 1'b0;
        model_cnt[0] = 0;
        wait_idle();
        read_cnt("wr_vs_hit_cnt", 3'd0, model_cnt[0]);

        // Reset in the middle of a scan: no ack, table and counters cleared.
        data = mk_key(IP3, 1'b0);
        req  = 1'b1;
        @(negedge sys_clk);
        req = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("rst_mid_outputs", 64'({busy, ack, err, fwd, hit_idx}), 64'(0));
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_cnt[i] = 0;
        repeat (12) @(negedge sys_clk);
        check("rst_busy", 64'(busy), 64'(0));
        for (int i = 0; i < DEPTH; i++) read_cnt("rst_cnt", IW'(i), model_cnt[i]);
        lookup(IP2, 1'b0, 1'b1, '0, '0);
        lookup(IP7, 1'b0, 1'b1, '0, '0);

        repeat (4) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
